// File: rtl/uart_32_bit_tx_scheduler.sv
// uart_32_bit_tx_scheduler: programs the UART baud divisor, then round-robins two word
// requesters onto the transmitter and serves single-word reads of the receive register.
module uart_32_bit_tx_scheduler #(
   parameter logic [31:0] BAUD_DIV  = 32'd130,
   parameter int          TX_CYCLES = 5200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [31:0] req_data0,
   input  logic [31:0] req_data1,
   output logic [1:0]  ack,
   input  logic        rd_req,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic [1:0]  uart_address,
   output logic        uart_write_enable,
   output logic [31:0] uart_write_data,
   output logic        uart_read_enable,
   input  logic [31:0] uart_read_data
);
   typedef enum logic [3:0] {
      S_CFG, S_IDLE, S_LOAD, S_START, S_WAIT, S_STOP, S_ACK, S_RD, S_RD_CAP
   } state_t;
   state_t      r_state, w_next;
   logic        r_grant, r_last_grant, r_rd_last;
   logic [31:0] r_word, r_rd_data;
   logic [15:0] r_cnt;
   logic        w_gnt, w_take_rd, w_take_tx;
   assign w_gnt     = (req == 2'b11) ? ~r_last_grant : req[1];
   // A read that just finished yields the next IDLE visit to a pending transmit
   assign w_take_rd = rd_req && !(r_rd_last && |req);
   assign w_take_tx = !w_take_rd && |req;
   always_comb begin
      w_next            = r_state;
      uart_address      = 2'd0;
      uart_write_enable = 1'b0;
      uart_write_data   = 32'd0;
      uart_read_enable  = 1'b0;
      ack               = 2'b00;
      rd_valid          = 1'b0;
      rd_data           = r_rd_data;
      busy              = r_state != S_IDLE;
      case (r_state)
         S_CFG: begin
            w_next            = S_IDLE;
            uart_write_enable = 1'b1;
            uart_write_data   = BAUD_DIV;
         end
         S_IDLE:  w_next = w_take_rd ? S_RD : (w_take_tx ? S_LOAD : S_IDLE);
         S_LOAD: begin
            w_next            = S_START;
            uart_address      = 2'd2;
            uart_write_enable = 1'b1;
            uart_write_data   = r_word;
         end
         S_START: begin
            w_next            = S_WAIT;
            uart_address      = 2'd1;
            uart_write_enable = 1'b1;
            uart_write_data   = 32'd1;
         end
         S_WAIT:  w_next = (r_cnt == 16'd0) ? S_STOP : S_WAIT;
         S_STOP: begin
            w_next            = S_ACK;
            uart_address      = 2'd1;
            uart_write_enable = 1'b1;
         end
         S_ACK: begin
            w_next = S_IDLE;
            ack    = {r_grant, ~r_grant};
         end
         S_RD: begin
            w_next           = S_RD_CAP;
            uart_address     = 2'd3;
            uart_read_enable = 1'b1;
         end
         S_RD_CAP: begin
            w_next   = S_IDLE;
            rd_valid = 1'b1;
            rd_data  = uart_read_data;
         end
         default: w_next = S_CFG;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_CFG;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_rd_last    <= 1'b0;
         r_word       <= 32'd0;
         r_rd_data    <= 32'd0;
         r_cnt        <= 16'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && !w_take_rd) r_rd_last <= 1'b0;
         if (r_state == S_IDLE && w_take_tx) begin
            r_grant      <= w_gnt;
            r_last_grant <= w_gnt;
            r_word       <= w_gnt ? req_data1 : req_data0;
         end
         if (r_state == S_START) r_cnt <= 16'(TX_CYCLES - 1);
         else if (r_state == S_WAIT && r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
         if (r_state == S_RD_CAP) begin
            r_rd_data <= uart_read_data;
            r_rd_last <= 1'b1;
         end
      end
   end
endmodule
